tcdm_bank_responder: RTL and testbench
======================================

Name: tcdm_bank_responder

Overview:
- Memory-side end of the HCI TCDM protocol; one instance per TCDM bank behind the cluster HCI interconnect.
- Accepts req/gnt requests, performs byte-masked reads and writes on an internal single-port word array, and returns in-order responses with a 1-cycle SRAM read latency.
- Responses are buffered in a response FIFO governed by r_ready backpressure.
- Replaces the bare SRAM macro hookup and provides a protocol-checked target for interconnect verification.

Parameters:
- DW, 32, data width in bits.
- BW, 8, bits per byte-enable lane; BE width = DW/BW.
- AW, 32, request address width.
- IW, 8, request/response ID width.
- UW, 1, user sideband width.
- NB_WORDS, 1024, words in the bank; word index = add[$clog2(NB_WORDS)+1:2].
- RSP_DEPTH, 2, response FIFO depth (>=1).
- FILTER_WRITE_R_VALID, 0, 1 = writes produce no response.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- tcdm_req_i  in  1  request valid
- tcdm_gnt_o  out  1  request accepted this cycle
- tcdm_add_i  in  AW  byte address
- tcdm_wen_i  in  1  1 = read, 0 = write
- tcdm_data_i  in  DW  write data
- tcdm_be_i  in  DW/BW  byte enables
- tcdm_id_i  in  IW  transaction ID
- tcdm_user_i  in  UW  user sideband
- tcdm_r_data_o  out  DW  response data
- tcdm_r_valid_o  out  1  response valid
- tcdm_r_ready_i  in  1  initiator accepts response
- tcdm_r_id_o  out  IW  echoed ID
- tcdm_r_user_o  out  UW  echoed user
- tcdm_r_opc_o  out  1  0 = OK, 1 = error (out of range)

Behaviour:
- Reset: one clock, clk_i; reset rst_i is asynchronous and active-high.
  - Asserting rst_i empties the FIFO, clears the credit counter and drops any in-flight read.
  - All outputs go to 0 (r_valid_o=0, r_data_o=0, r_id_o=0, r_user_o=0, r_opc_o=0). gnt_o=0 while rst_i is high.
  - Array contents are not reset.
  - Reset mid-transaction discards all pending responses; the first request after deassertion is treated as fresh.
- Credits: outstanding = FIFO occupancy + in-flight (0/1). A transaction counts as response-generating unless it is a write with FILTER_WRITE_R_VALID=1.
- Grant rule:
  - gnt_o = req_i && (outstanding < RSP_DEPTH || (r_valid_o && r_ready_i)).
  - Combinational on r_ready_i; no combinational path from req_i to r_*.
  - Non-response-generating writes are always granted outside reset.
- Handshake: a transfer occurs when req_i && gnt_o. Address, data, be, id and user are sampled only on that edge. req_i may be held or dropped freely while gnt_o=0.
- Write:
  - Lanes with be=1 are updated at the grant edge; lanes with be=0 are unchanged.
  - Response (if not filtered): r_data=0, r_opc=0, enqueued at grant+1.
- Read:
  - The array is read at the grant edge; the response is enqueued at grant+1.
  - Minimum latency: gnt at cycle N gives r_valid_o at cycle N+1 when the FIFO is empty.
  - Read-after-write to the same word in consecutive grants returns the new data.
  - A single port needs no same-cycle conflict handling.
- Out of range:
  - Condition: word index >= NB_WORDS, or any address bit above the index field nonzero.
  - No array access; response r_opc=1, r_data=0. Filtered writes that are out of range are silently dropped.
- FIFO:
  - In-order. r_valid_o = FIFO non-empty; the head pops on r_valid_o && r_ready_i.
  - r_* outputs stay stable while r_valid_o && !r_ready_i.
  - Push and pop in the same cycle are both honored, including when full with pop (so full throughput is 1/cycle with r_ready held high).
  - Empty with push gives valid next cycle; no bypass.
- Backpressure: with r_ready_i low, at most RSP_DEPTH responses are outstanding; gnt_o then drops until a pop.
- Assertion (sim only): a push when full is an error.

Test Plan:
- Reset, then write 0xDEADBEEF be=0xF to 0x40, id=3, FILTER=0 → gnt same cycle; r_valid next cycle, r_id=3, r_opc=0. Read 0x40 id=5 → r_data=0xDEADBEEF, r_id=5 at grant+1.
- Byte enables: after the above, write 0x11223344 be=0x5 to 0x40, then read → r_data=0xDE22BE44.
- Backpressure: r_ready=0, 4 back-to-back reads, RSP_DEPTH=2 → only 2 grants, gnt low afterwards. Raise r_ready → responses in ID order, remaining grants issued, no response lost or duplicated.
- Throughput: r_ready=1, 16 consecutive reads → 16 grants in 16 cycles; r_valid continuous from cycle 2.
- Error: read at word index NB_WORDS (byte address 0x1000 with defaults) → r_opc=1, r_data=0. With FILTER=1, out-of-range write → no response, memory unchanged.
- Reset mid-operation: with 2 responses queued and r_ready=0, pulse rst_i asynchronously → r_valid_o=0 immediately. After release, new read granted with full credits and correct data.

Source files
------------

// File: rtl/tcdm_bank_responder.sv
// tcdm_bank_responder: memory-side target for one TCDM bank behind the HCI interconnect.
// Accepts req/gnt requests and performs byte-masked reads and writes on a single-port word
// array. Responses come back in order through a small response FIFO, which r_ready throttles.
//
// Ports:
//   clk_i, rst_i             clock; asynchronous active-high reset
//   tcdm_req_i / tcdm_gnt_o  request handshake (transfer when both are high)
//   tcdm_add_i               byte address; the word index is add[$clog2(NB_WORDS)+1:2]
//   tcdm_wen_i               1 = read, 0 = write
//   tcdm_data_i, tcdm_be_i   write data and byte-lane enables
//   tcdm_id_i, tcdm_user_i   transaction tag and sideband, echoed on the response
//   tcdm_r_*                 response channel (valid/ready, data, id, user, opc; opc=1 is error)
module tcdm_bank_responder #(
  parameter int unsigned DW                   = 32,
  parameter int unsigned BW                   = 8,
  parameter int unsigned AW                   = 32,
  parameter int unsigned IW                   = 8,
  parameter int unsigned UW                   = 1,
  parameter int unsigned NB_WORDS             = 1024,
  parameter int unsigned RSP_DEPTH            = 2,
  parameter bit          FILTER_WRITE_R_VALID = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tcdm_req_i,
  output logic             tcdm_gnt_o,
  input  logic [AW-1:0]    tcdm_add_i,
  input  logic             tcdm_wen_i,
  input  logic [DW-1:0]    tcdm_data_i,
  input  logic [DW/BW-1:0] tcdm_be_i,
  input  logic [IW-1:0]    tcdm_id_i,
  input  logic [UW-1:0]    tcdm_user_i,
  output logic [DW-1:0]    tcdm_r_data_o,
  output logic             tcdm_r_valid_o,
  input  logic             tcdm_r_ready_i,
  output logic [IW-1:0]    tcdm_r_id_o,
  output logic [UW-1:0]    tcdm_r_user_o,
  output logic             tcdm_r_opc_o
);

  localparam int unsigned BeW  = DW / BW;
  localparam int unsigned IdxW = $clog2(NB_WORDS);
  localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic [UW-1:0] user;
    logic          opc;
  } rsp_t;

  logic [DW-1:0]   mem_q [NB_WORDS];
  rsp_t            fifo_q [RSP_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [IdxW-1:0] idx;
  logic            in_range, is_write, rsp_gen, valid, pop, push, credit_ok;
  logic [DW-1:0]   wr_word;
  rsp_t            push_rsp, head;
  logic            unused_lsb;

  assign unused_lsb = ^tcdm_add_i[1:0];

  // Any address bit above the index field makes the access out of range.
  assign idx      = tcdm_add_i[IdxW+1:2];
  assign in_range = (tcdm_add_i[AW-1:IdxW+2] == '0) && (32'(idx) < NB_WORDS);
  assign is_write = ~tcdm_wen_i;
  assign rsp_gen  = ~(is_write & FILTER_WRITE_R_VALID);

  // Credits equal FIFO occupancy: the response entry is written at the grant edge, which
  // plays the role of the SRAM output register, so nothing is in flight outside the FIFO.
  assign valid     = (cnt_q != '0);
  assign pop       = valid & tcdm_r_ready_i;
  assign credit_ok = (32'(cnt_q) < RSP_DEPTH) | pop;
  assign tcdm_gnt_o = tcdm_req_i & ~rst_i & (~rsp_gen | credit_ok);
  assign push      = tcdm_gnt_o & rsp_gen;

  always_comb begin
    push_rsp      = '0;
    push_rsp.id   = tcdm_id_i;
    push_rsp.user = tcdm_user_i;
    push_rsp.opc  = ~in_range;
    if (!is_write && in_range) push_rsp.data = mem_q[idx];
  end

  // Merge enabled byte lanes into the stored word.
  always_comb begin
    wr_word = mem_q[idx];
    for (int b = 0; b < BeW; b++) begin
      if (tcdm_be_i[b]) wr_word[b*BW +: BW] = tcdm_data_i[b*BW +: BW];
    end
  end

  always_ff @(posedge clk_i) begin
    if (tcdm_gnt_o && is_write && in_range) mem_q[idx] <= wr_word;
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= push_rsp;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
    if (push) wr_ptr_d = (32'(wr_ptr_q) == RSP_DEPTH - 1) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (32'(rd_ptr_q) == RSP_DEPTH - 1) ? '0 : rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs are forced to zero while the FIFO is empty, so reset drives them low at once.
  always_comb begin
    head           = valid ? fifo_q[rd_ptr_q] : '0;
    tcdm_r_valid_o = valid;
    tcdm_r_data_o  = head.data;
    tcdm_r_id_o    = head.id;
    tcdm_r_user_o  = head.user;
    tcdm_r_opc_o   = head.opc;
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (rst_i)
                   !(push && !pop && (32'(cnt_q) == RSP_DEPTH)))
    else $error("push into full response FIFO");
`endif

endmodule

// File: tb/tb_tcdm_bank_responder.sv
module tb_tcdm_bank_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (writes produce responses)
  logic        req, gnt, wen, r_valid, r_ready, r_opc;
  logic [31:0] add, data, r_data;
  logic [3:0]  be;
  logic [7:0]  id, r_id;
  logic [0:0]  user, r_user;

  // Second DUT with write responses filtered
  logic        f_req, f_gnt, f_wen, f_r_valid, f_r_ready, f_r_opc;
  logic [31:0] f_add, f_data, f_r_data;
  logic [3:0]  f_be;
  logic [7:0]  f_id, f_r_id;
  logic [0:0]  f_user, f_r_user;

  tcdm_bank_responder dut (
    .clk_i(clk), .rst_i(rst),
    .tcdm_req_i(req), .tcdm_gnt_o(gnt), .tcdm_add_i(add), .tcdm_wen_i(wen),
    .tcdm_data_i(data), .tcdm_be_i(be), .tcdm_id_i(id), .tcdm_user_i(user),
    .tcdm_r_data_o(r_data), .tcdm_r_valid_o(r_valid), .tcdm_r_ready_i(r_ready),
    .tcdm_r_id_o(r_id), .tcdm_r_user_o(r_user), .tcdm_r_opc_o(r_opc)
  );

  tcdm_bank_responder #(.FILTER_WRITE_R_VALID(1'b1)) dut_f (
    .clk_i(clk), .rst_i(rst),
    .tcdm_req_i(f_req), .tcdm_gnt_o(f_gnt), .tcdm_add_i(f_add), .tcdm_wen_i(f_wen),
    .tcdm_data_i(f_data), .tcdm_be_i(f_be), .tcdm_id_i(f_id), .tcdm_user_i(f_user),
    .tcdm_r_data_o(f_r_data), .tcdm_r_valid_o(f_r_valid), .tcdm_r_ready_i(f_r_ready),
    .tcdm_r_id_o(f_r_id), .tcdm_r_user_o(f_r_user), .tcdm_r_opc_o(f_r_opc)
  );

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic        opc;
    logic        user;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [1024];
  int checks = 0, errors = 0;
  int cyc = 0, gnt_cnt = 0, valid_cnt = 0;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Response monitor: sampled on the falling edge, a response pops on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (req && gnt) gnt_cnt++;
    if (r_valid) valid_cnt++;
    if (r_valid && r_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", {56'd0, r_id}, 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("rsp_id", {56'd0, r_id}, {56'd0, e.id});
        check_eq("rsp_data", {32'd0, r_data}, {32'd0, e.data});
        check_eq("rsp_opc", {63'd0, r_opc}, {63'd0, e.opc});
        check_eq("rsp_user", {63'd0, r_user}, {63'd0, e.user});
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Issue one request starting just after a rising edge; returns cycles spent waiting.
  task automatic do_req(input logic w_en, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [7:0] t, output int waited);
    exp_t        e;
    logic [9:0]  widx;
    logic        inr;
    req = 1'b1; wen = w_en; add = a; data = d; be = b; id = t; user = t[0];
    waited = 0;
    forever begin
      @(negedge clk);
      if (gnt) break;
      waited++;
      if (waited >= 50) begin
        check_eq("gnt_timeout", 64'd0, 64'd1);
        req = 1'b0;
        return;
      end
    end
    widx = a[11:2];
    inr  = (a[31:12] == 20'd0);
    e.id = t; e.user = t[0]; e.opc = ~inr; e.data = 32'd0;
    if (w_en) begin
      if (inr) e.data = model[widx];
    end else if (inr) begin
      for (int k = 0; k < 4; k++) if (b[k]) model[widx][k*8 +: 8] = d[k*8 +: 8];
    end
    exp_q.push_back(e);
    sync();
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) sync();
  endtask

  initial begin
    int w, w2, c0, g0, v0, base, fvc;
    req = 1'b1; wen = 1'b1; add = '0; data = '0; be = '0; id = '0; user = '0; r_ready = 1'b1;
    f_req = 1'b0; f_wen = 1'b1; f_add = '0; f_data = '0; f_be = 4'hF; f_id = '0; f_user = '0;
    f_r_ready = 1'b1;
    for (int i = 0; i < 1024; i++) model[i] = 32'd0;

    // Reset state, with a request pending to show gnt stays low.
    #1 rst = 1'b1;
    #1;
    check_eq("rst_gnt", {63'd0, gnt}, 64'd0);
    check_eq("rst_valid", {63'd0, r_valid}, 64'd0);
    check_eq("rst_data", {32'd0, r_data}, 64'd0);
    check_eq("rst_id", {56'd0, r_id}, 64'd0);
    check_eq("rst_opc", {63'd0, r_opc}, 64'd0);
    check_eq("rst_user", {63'd0, r_user}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; req = 1'b0;
    idle(2);

    // Write then read back; grant same cycle, response next cycle.
    do_req(1'b0, 32'h40, 32'hDEADBEEF, 4'hF, 8'd3, w);
    check_eq("wr_gnt_wait", 64'(w), 64'd0);
    req = 1'b0;
    @(negedge clk);
    check_eq("wr_rsp_valid", {63'd0, r_valid}, 64'd1);
    check_eq("wr_rsp_id", {56'd0, r_id}, 64'd3);
    sync();
    do_req(1'b1, 32'h40, 32'd0, 4'hF, 8'd5, w);
    req = 1'b0;
    @(negedge clk);
    check_eq("rd_data", {32'd0, r_data}, 64'hDEADBEEF);
    check_eq("rd_id", {56'd0, r_id}, 64'd5);
    sync();

    // Byte-enable merge with read-after-write in consecutive grants.
    do_req(1'b0, 32'h40, 32'h11223344, 4'h5, 8'd6, w);
    do_req(1'b1, 32'h40, 32'd0, 4'hF, 8'd7, w);
    req = 1'b0;
    @(negedge clk);
    check_eq("be_data", {32'd0, r_data}, 64'hDE22BE44);
    sync();

    // Backpressure: four reads with r_ready low, only RSP_DEPTH granted.
    idle(3);
    r_ready = 1'b0;
    base = gnt_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++) do_req(1'b1, 32'h40, 32'd0, 4'hF, 8'(10 + i), w);
        req = 1'b0;
      end
      begin
        repeat (6) @(negedge clk);
        #1;
        check_eq("bp_grants", 64'(gnt_cnt - base), 64'd2);
        check_eq("bp_gnt_low", {63'd0, gnt}, 64'd0);
        check_eq("bp_head_id", {56'd0, r_id}, 64'd10);
        @(posedge clk);
        #1 r_ready = 1'b1;
      end
    join
    idle(4);
    check_eq("bp_all_grants", 64'(gnt_cnt - base), 64'd4);
    check_eq("bp_drained", 64'(exp_q.size()), 64'd0);

    // Throughput: 16 reads back-to-back with r_ready high.
    for (int i = 0; i < 16; i++)
      do_req(1'b0, 32'h100 + 32'(4 * i), 32'hA5000000 ^ (32'(i) * 32'h01010101), 4'hF,
             8'(16 + i), w);
    idle(3);
    c0 = cyc; g0 = gnt_cnt; v0 = valid_cnt;
    for (int i = 0; i < 16; i++) do_req(1'b1, 32'h100 + 32'(4 * i), 32'd0, 4'hF, 8'(32 + i), w);
    req = 1'b0;
    check_eq("tp_cycles", 64'(cyc - c0), 64'd16);
    @(negedge clk);
    #1;
    check_eq("tp_grants", 64'(gnt_cnt - g0), 64'd16);
    check_eq("tp_valid_cycles", 64'(valid_cnt - v0), 64'd16);
    sync();

    // Out of range: read at word index NB_WORDS, write with a high address bit set.
    do_req(1'b1, 32'h1000, 32'd0, 4'hF, 8'd50, w);
    req = 1'b0;
    @(negedge clk);
    check_eq("oor_opc", {63'd0, r_opc}, 64'd1);
    check_eq("oor_data", {32'd0, r_data}, 64'd0);
    sync();
    do_req(1'b0, 32'h2040, 32'h0BADF00D, 4'hF, 8'd51, w);
    do_req(1'b1, 32'h40, 32'd0, 4'hF, 8'd52, w);
    idle(3);

    // Reset mid-operation with two responses queued.
    r_ready = 1'b0;
    do_req(1'b1, 32'h40, 32'd0, 4'hF, 8'd60, w);
    do_req(1'b1, 32'h104, 32'd0, 4'hF, 8'd61, w);
    idle(2);
    check_eq("pre_rst_valid", {63'd0, r_valid}, 64'd1);
    #3 rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", {63'd0, r_valid}, 64'd0);
    req = 1'b1;
    #1;
    check_eq("mid_rst_gnt", {63'd0, gnt}, 64'd0);
    req = 1'b0;
    exp_q.delete();
    sync();
    rst = 1'b0;
    do_req(1'b1, 32'h40, 32'd0, 4'hF, 8'd62, w);
    do_req(1'b1, 32'h100, 32'd0, 4'hF, 8'd63, w2);
    req = 1'b0;
    check_eq("post_rst_credits", 64'(w + w2), 64'd0);
    r_ready = 1'b1;
    idle(4);
    check_eq("post_rst_drained", 64'(exp_q.size()), 64'd0);

    // Filtered writes: no response, out-of-range write dropped, always granted.
    f_wen = 1'b0; f_add = 32'h80; f_data = 32'hCAFEF00D; f_req = 1'b1;
    @(negedge clk);
    check_eq("f_wr_gnt", {63'd0, f_gnt}, 64'd1);
    sync();
    f_add = 32'h1080; f_data = 32'h12345678;
    @(negedge clk);
    check_eq("f_oor_gnt", {63'd0, f_gnt}, 64'd1);
    sync();
    f_req = 1'b0;
    fvc = 0;
    repeat (3) begin
      @(negedge clk);
      if (f_r_valid) fvc++;
    end
    check_eq("f_no_rsp", 64'(fvc), 64'd0);
    sync();
    f_r_ready = 1'b0;
    f_wen = 1'b1; f_add = 32'h80; f_id = 8'd9; f_req = 1'b1;
    @(negedge clk);
    check_eq("f_rd_gnt", {63'd0, f_gnt}, 64'd1);
    sync();
    f_id = 8'd10;
    @(negedge clk);
    check_eq("f_rd2_gnt", {63'd0, f_gnt}, 64'd1);
    check_eq("f_rd_data", {32'd0, f_r_data}, 64'hCAFEF00D);
    check_eq("f_rd_id", {56'd0, f_r_id}, 64'd9);
    check_eq("f_rd_opc", {63'd0, f_r_opc}, 64'd0);
    sync();
    @(negedge clk);
    check_eq("f_full_rd_gnt", {63'd0, f_gnt}, 64'd0);
    f_wen = 1'b0; f_add = 32'h84;
    #1;
    check_eq("f_full_wr_gnt", {63'd0, f_gnt}, 64'd1);
    sync();
    f_req = 1'b0;
    f_r_ready = 1'b1;
    repeat (3) sync();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
